// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg - oversampled UART receiver with runtime-selectable parity and
// stop-bit count, per-word parity/framing error flags and a one-clock valid.
//
// Optional build macro: UART_RX_MAJORITY_EN
//   defined   : each bit resolved by 2-of-3 majority over ticks S-1, S, S+1
//               (decision taken at S+1, S = OVERSAMPLE/2)
//   undefined : single sample at tick S
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,   // 5..9, LSB first on the line
  parameter int OVERSAMPLE = 16   // even, >= 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 rxen,
  input  logic                 tick,
  input  logic                 rxd,
  input  logic [1:0]           par_mode,
  input  logic                 stop2,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

`ifdef UART_RX_MAJORITY_EN
  localparam int SAMPLE_PH = OVERSAMPLE / 2 + 1;
`else
  localparam int SAMPLE_PH = OVERSAMPLE / 2;
`endif

  // A tick whose counter value equals PRE_SAMPLE is the sample tick; the
  // counter is cleared on the start-detect tick, so that tick is phase 0.
  localparam logic [TW-1:0] PRE_SAMPLE = TW'(SAMPLE_PH - 1);
  localparam logic [TW-1:0] LAST_PH    = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BITS_END   = BW'(DATA_BITS);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic                 rxd_meta_q, rxd_s_q;
  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_en_q, par_en_d;
  logic                 par_odd_q, par_odd_d;
  logic                 stop2_q, stop2_d;
  logic                 par_bit_q, par_bit_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  logic sample_now;
  logic wrap;
  logic bit_val;
  logic final_stop;

  // Two-flop synchroniser on the asynchronous serial line.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      // NOTE: preset to 1 (idle line) so reset release never looks like a start bit.
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its source.
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q, hist_d;

  // History of the two previous tick samples for the 2-of-3 vote.
  always_comb begin
    hist_d = tick ? {hist_q[0], rxd_s_q} : hist_q;
  end

  // Sample history register, idle-high after reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) hist_q <= 2'b11;
    else        hist_q <= hist_d;
  end

  assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxd_s_q) | (hist_q[0] & rxd_s_q);
`else
  assign bit_val = rxd_s_q;
`endif

  assign sample_now = tick && (tick_cnt_q == PRE_SAMPLE);
  assign wrap       = tick && (tick_cnt_q == LAST_PH);
  assign final_stop = !stop2_q || (bit_cnt_q != '0);

  // Next-state and datapath decode for the receive FSM.
  always_comb begin
    // NOTE: every _d defaults to its _q first so no path leaves a latch behind.
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop2_d    = stop2_q;
    par_bit_d  = par_bit_q;
    ferr_acc_d = ferr_acc_q;
    rx_data_d  = rx_data_q;
    valid_d    = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;

    if (tick) begin
      tick_cnt_d = (tick_cnt_q == LAST_PH) ? '0 : tick_cnt_q + 1'b1;
    end

    if (!rxen) begin
      // Receiver disabled: drop any partial word, leave outputs as they were.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tick && !rxd_s_q) begin
            state_d    = ST_START;
            tick_cnt_d = '0;
            par_en_d   = (par_mode == 2'd1) || (par_mode == 2'd2);
            par_odd_d  = (par_mode == 2'd2);
            stop2_d    = stop2;
            ferr_acc_d = 1'b0;
          end
        end

        ST_START: begin
          if (sample_now && bit_val) begin
            state_d = ST_IDLE;               // glitch, not a real start bit
          end else if (wrap) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end

        ST_DATA: begin
          if (sample_now) begin
            shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (wrap && (bit_cnt_q == BITS_END)) begin
            state_d   = par_en_q ? ST_PARITY : ST_STOP;
            bit_cnt_d = '0;                  // reused as stop-bit index
          end
        end

        ST_PARITY: begin
          if (sample_now) begin
            par_bit_d = bit_val;
          end else if (wrap) begin
            state_d = ST_STOP;
          end
        end

        ST_STOP: begin
          if (sample_now) begin
            if (!bit_val) ferr_acc_d = 1'b1;
            if (final_stop) begin
              // Leave without waiting for the wrap so a 1-stop-bit frame can follow immediately.
              state_d   = ST_IDLE;
              valid_d   = 1'b1;
              rx_data_d = shift_q;
              perr_d    = par_en_q && ((^shift_q ^ par_bit_q) != par_odd_q);
              ferr_d    = ferr_acc_q || !bit_val;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM, counters, shift register and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      par_bit_q  <= 1'b0;
      ferr_acc_q <= 1'b0;
      rx_data_q  <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      stop2_q    <= stop2_d;
      par_bit_q  <= par_bit_d;
      ferr_acc_q <= ferr_acc_d;
      rx_data_q  <= rx_data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg - randomized and directed frames against a frame-level
// reference model. Two receivers: 8-bit/16x on rxd, 7-bit/8x on rxd7.
module tb_uart_rx_cfg;

  localparam int DB0 = 8;
  localparam int OS0 = 16;
  localparam int DB7 = 7;
  localparam int OS7 = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic           clk = 1'b0;
  logic           n_rst, rxen, tick, rxd, rxd7, stop2;
  logic [1:0]     par_mode;
  logic [DB0-1:0] rx_data;
  logic           valid, parity_err, frame_err, busy;
  logic [DB7-1:0] rx_data7;
  logic           valid7, parity_err7, frame_err7, busy7;

  int n_cmp = 0;
  int n_bad = 0;
  int tick_num = 0;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    int         tnum;
  } rec_t;

  rec_t q0[$];
  rec_t q7[$];

  uart_rx_cfg #(.DATA_BITS(DB0), .OVERSAMPLE(OS0)) u_dut (
    .clk(clk), .n_rst(n_rst), .rxen(rxen), .tick(tick), .rxd(rxd),
    .par_mode(par_mode), .stop2(stop2), .rx_data(rx_data), .valid(valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  uart_rx_cfg #(.DATA_BITS(DB7), .OVERSAMPLE(OS7)) u_dut7 (
    .clk(clk), .n_rst(n_rst), .rxen(rxen), .tick(tick), .rxd(rxd7),
    .par_mode(par_mode), .stop2(stop2), .rx_data(rx_data7), .valid(valid7),
    .parity_err(parity_err7), .frame_err(frame_err7), .busy(busy7)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Record every valid pulse with the number of ticks issued so far.
  always @(negedge clk) begin
    if (valid === 1'b1)
      q0.push_back('{data: 9'(rx_data), perr: parity_err, ferr: frame_err, tnum: tick_num});
    if (valid7 === 1'b1)
      q7.push_back('{data: 9'(rx_data7), perr: parity_err7, ferr: frame_err7, tnum: tick_num});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One oversample period: set the line, let it settle through the
  // synchroniser, then issue a single-clock tick that sees it.
  task automatic drive_tick(input int sel, input logic v);
    @(negedge clk);
    if (sel == 0) rxd = v;
    else          rxd7 = v;
    repeat (2) @(negedge clk);
    tick = 1'b1;
    tick_num++;
    @(negedge clk);
    tick = 1'b0;
  endtask

  // Serialize one frame; glitch inverts one tick, cut truncates the frame.
  task automatic send_frame(input int sel, input logic [8:0] data, input int db, input int os,
                            input bit has_par, input logic pbit, input int nstop,
                            input logic [1:0] stops, input int glitch, input bit scramble,
                            input int cut, output int n0);
    logic bits[$];
    int   len;
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < db; i++) bits.push_back(data[i]);
    if (has_par) bits.push_back(pbit);
    for (int i = 0; i < nstop; i++) bits.push_back(stops[i]);
    len = bits.size() * os;
    if (cut >= 0 && cut < len) len = cut;
    n0 = tick_num;
    for (int t = 0; t < len; t++) begin
      logic v;
      v = bits[t / os];
      if (t == glitch) v = ~v;
      if (scramble && t == 2 * os) begin
        par_mode = 2'($urandom_range(0, 3));
        stop2    = 1'($urandom_range(0, 1));
      end
      drive_tick(sel, v);
    end
  endtask

  task automatic idle_ticks(input int sel, input int n);
    for (int i = 0; i < n; i++) drive_tick(sel, 1'b1);
  endtask

  // Reference: parity error from the frame's data and the bit on the line.
  function automatic logic model_perr(input logic [1:0] mode, input logic [8:0] data,
                                      input int db, input logic pbit);
    logic x;
    x = 1'b0;
    for (int i = 0; i < db; i++) x = x ^ data[i];
    if (mode == 2'd1) return x ^ pbit;
    if (mode == 2'd2) return ~(x ^ pbit);
    return 1'b0;
  endfunction

  // Reference: ticks issued when valid is seen = final stop sample index + 1.
  function automatic int exp_tnum(input int n0, input int db, input int os,
                                  input bit hp, input int nst);
    return n0 + (db + int'(hp) + nst) * os + os / 2 + MAJ + 1;
  endfunction

  task automatic expect_frame(input int sel, input string tag, input logic [8:0] d,
                              input logic pe, input logic fe, input int tn, output int got_tn);
    rec_t r;
    int   n;
    got_tn = -1;
    n = (sel == 0) ? q0.size() : q7.size();
    check({tag, ".nvalid"}, n, 1);
    if (n > 0) begin
      if (sel == 0) r = q0.pop_front();
      else          r = q7.pop_front();
      got_tn = r.tnum;
      check({tag, ".data"}, r.data, d);
      check({tag, ".perr"}, r.perr, pe);
      check({tag, ".ferr"}, r.ferr, fe);
      check({tag, ".time"}, r.tnum, tn);
    end
    q0.delete();
    q7.delete();
  endtask

  initial begin
    int         n0, n0b, ta, tb;
    logic [8:0] last_d0;

    n_rst = 1'b0; rxen = 1'b1; tick = 1'b0; rxd = 1'b1; rxd7 = 1'b1;
    par_mode = 2'd0; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.data", rx_data, 0);
    check("rst.valid", valid, 0);
    check("rst.perr", parity_err, 0);
    check("rst.ferr", frame_err, 0);
    check("rst.busy", busy, 0);
    check("rst.busy7", busy7, 0);
    n_rst = 1'b1;
    idle_ticks(0, 2 * OS0);

    // 8N1 0xA5
    send_frame(0, 9'h0A5, DB0, OS0, 0, 1'b0, 1, 2'b11, -1, 0, -1, n0);
    expect_frame(0, "a5", 9'h0A5, 0, 0, exp_tnum(n0, DB0, OS0, 0, 1), ta);
    check("a5.busy", busy, 0);

    // even parity, wrong parity bit
    par_mode = 2'd1;
    send_frame(0, 9'h007, DB0, OS0, 1, 1'b0, 1, 2'b11, -1, 0, -1, n0);
    expect_frame(0, "even07", 9'h007, 1, 0, exp_tnum(n0, DB0, OS0, 1, 1), ta);
    // odd parity, same parity bit is now correct
    par_mode = 2'd2;
    send_frame(0, 9'h007, DB0, OS0, 1, 1'b0, 1, 2'b11, -1, 0, -1, n0);
    expect_frame(0, "odd07", 9'h007, 0, 0, exp_tnum(n0, DB0, OS0, 1, 1), ta);

    // low stop bit, then a clean frame
    par_mode = 2'd0;
    send_frame(0, 9'h03C, DB0, OS0, 0, 1'b0, 1, 2'b00, -1, 0, -1, n0);
    expect_frame(0, "stop3c", 9'h03C, 0, 1, exp_tnum(n0, DB0, OS0, 0, 1), ta);
    idle_ticks(0, OS0);
    send_frame(0, 9'h055, DB0, OS0, 0, 1'b0, 1, 2'b11, -1, 0, -1, n0);
    expect_frame(0, "clean55", 9'h055, 0, 0, exp_tnum(n0, DB0, OS0, 0, 1), ta);
    last_d0 = 9'h055;

    // false start: 4 low ticks from idle
    for (int t = 0; t < 4; t++) drive_tick(0, 1'b0);
    check("fstart.busy_on", busy, 1);
    idle_ticks(0, OS0 / 2 + MAJ);
    check("fstart.busy_off", busy, 0);
    idle_ticks(0, OS0);
    check("fstart.nvalid", q0.size(), 0);
    check("fstart.data", rx_data, last_d0);

    // break: all zeros including the stop bit
    send_frame(0, 9'h000, DB0, OS0, 0, 1'b0, 1, 2'b00, -1, 0, -1, n0);
    expect_frame(0, "break", 9'h000, 0, 1, exp_tnum(n0, DB0, OS0, 0, 1), ta);
    idle_ticks(0, OS0);

    // single-tick glitch at the centre tick of data bit 3
    send_frame(0, 9'h000, DB0, OS0, 0, 1'b0, 1, 2'b11, 4 * OS0 + OS0 / 2, 0, -1, n0);
    expect_frame(0, "glitch", (MAJ != 0) ? 9'h000 : 9'h008, 0, 0,
                 exp_tnum(n0, DB0, OS0, 0, 1), ta);
    last_d0 = (MAJ != 0) ? 9'h000 : 9'h008;

    // rxen dropped mid-frame
    for (int t = 0; t < OS0 + 20; t++) drive_tick(0, (t < OS0) ? 1'b0 : 1'b1);
    check("rxen.busy_on", busy, 1);
    @(negedge clk); rxen = 1'b0;
    @(negedge clk); check("rxen.busy_off", busy, 0);
    rxen = 1'b1;
    idle_ticks(0, 9 * OS0);
    check("rxen.nvalid", q0.size(), 0);
    check("rxen.data", rx_data, last_d0);

    // randomized frames; mode/stop inputs scrambled mid-frame
    for (int k = 0; k < 30; k++) begin
      logic [8:0] d;
      logic [1:0] m, st;
      logic       s2, pb, good, fe;
      bit         hp;
      int         nst, gap;
      d  = 9'($urandom_range(0, 255));
      m  = 2'($urandom_range(0, 3));
      s2 = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      good = ^d[7:0];
      if (m == 2'd2) good = ~good;
      pb = ($urandom_range(0, 2) == 0) ? ~good : good;
      if (k == 5) begin d = 9'h000; st = 2'b00; pb = 1'b0; end
      hp  = (m == 2'd1) || (m == 2'd2);
      nst = s2 ? 2 : 1;
      par_mode = m;
      stop2    = s2;
      send_frame(0, d, DB0, OS0, hp, pb, nst, st, -1, 1, -1, n0);
      fe = !st[0] || (nst == 2 && !st[1]);
      expect_frame(0, "rnd", d, model_perr(m, d, DB0, pb), fe, exp_tnum(n0, DB0, OS0, hp, nst), ta);
      gap = (!st[nst-1]) ? 1 + $urandom_range(0, 1) : $urandom_range(0, 2);
      idle_ticks(0, gap * OS0);
    end

    // 7-bit, two stop bits, back-to-back on the second receiver
    par_mode = 2'd0; stop2 = 1'b1;
    idle_ticks(1, 2 * OS7);
    send_frame(1, 9'h041, DB7, OS7, 0, 1'b0, 2, 2'b11, -1, 0, -1, n0);
    expect_frame(1, "b2b41", 9'h041, 0, 0, exp_tnum(n0, DB7, OS7, 0, 2), ta);
    send_frame(1, 9'h07F, DB7, OS7, 0, 1'b0, 2, 2'b11, -1, 0, -1, n0b);
    expect_frame(1, "b2b7f", 9'h07F, 0, 0, exp_tnum(n0b, DB7, OS7, 0, 2), tb);
    check("b2b.spacing", tb - ta, 10 * OS7);

    // reset in the middle of the second of two frames
    send_frame(1, 9'h041, DB7, OS7, 0, 1'b0, 2, 2'b11, -1, 0, -1, n0);
    expect_frame(1, "pre41", 9'h041, 0, 0, exp_tnum(n0, DB7, OS7, 0, 2), ta);
    send_frame(1, 9'h07F, DB7, OS7, 0, 1'b0, 2, 2'b11, -1, 0, 3 * OS7, n0);
    check("mid.busy7", busy7, 1);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("mrst.data7", rx_data7, 0);
    check("mrst.valid7", valid7, 0);
    check("mrst.perr7", parity_err7, 0);
    check("mrst.ferr7", frame_err7, 0);
    check("mrst.busy7", busy7, 0);
    check("mrst.data", rx_data, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Parametrised successor UART receiver in the UART/CAL datapath; replaces the fixed 8N1 receiver.
- Features: oversampled mid-bit sampling, runtime-selectable parity and stop bits, and per-frame error flags.
- Consumes an oversample strobe from the shared baud generator.
- Delivers one-cycle-valid words to the calculator command parser.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9), LSB first.
- OVERSAMPLE, 16, tick strobes per bit period (even, >=8).

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- rxen  input  1  receiver enable; low forces IDLE
- tick  input  1  oversample strobe, 1 clk wide, rate = baud*OVERSAMPLE
- rxd  input  1  serial line, asynchronous, idle high
- par_mode  input  2  0 none, 1 even, 2 odd, 3 treated as none
- stop2  input  1  0 = one stop bit, 1 = two stop bits
- rx_data  output  DATA_BITS  received word
- valid  output  1  one-clk pulse, new word on rx_data
- parity_err  output  1  parity mismatch for the word on rx_data
- frame_err  output  1  stop bit sampled low for the word on rx_data
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, n_rst low): state IDLE; rx_data=0, valid=0, parity_err=0, frame_err=0, busy=0; synchroniser flops set to 1.
- rxd passes a 2-FF synchroniser (rxd_s), initialised high. rxd_s is the only rxd observed by the FSM.
- tick_cnt, width $clog2(OVERSAMPLE):
  - Advances only on tick.
  - Wraps OVERSAMPLE-1 -> 0; each wrap moves to the next bit.
  - Sample phase S = OVERSAMPLE/2.
- bit_cnt, width $clog2(DATA_BITS+1).
- States IDLE, START, DATA, PARITY, STOP.
- IDLE: on tick with rxen=1 and rxd_s=0 -> START, tick_cnt=0.
  - par_mode and stop2 are latched here.
  - Changes to par_mode or stop2 mid-frame are ignored.
- START: at sample point, rxd_s=1 -> IDLE (false start, no valid, no flags). Otherwise continue; at wrap -> DATA, bit_cnt=0.
- DATA:
  - At the sample point, shift the sample in at the MSB (LSB-first line order); bit_cnt++.
  - At wrap after bit_cnt==DATA_BITS: -> PARITY if latched parity enabled, else -> STOP.
- PARITY: sample bit; parity_err_next = (XOR(data)^sample) != (mode==odd). At wrap -> STOP.
- STOP:
  - Sample each stop bit; any 0 sample sets frame_err_next.
  - After the final stop-bit sample (1st, or 2nd if stop2), go directly to IDLE; the wrap is not waited for.
  - This allows back-to-back frames with 1-bit stop.
- Output timing: valid=1 for exactly one clk, in the cycle after the final stop sample.
  - rx_data, parity_err and frame_err update in that same cycle.
  - They hold until the next valid; they are never cleared to 0 in between.
- Errored frames still produce valid (flags set, data delivered).
- A received break gives data 0 with frame_err=1.
- rxen deasserted mid-frame: next clk -> IDLE, partial word discarded, no valid, outputs unchanged.
- tick absent: FSM holds; a tick stretched across clocks is undefined (the baud generator guarantees 1-clk strobes).
- Simultaneous final stop sample and rxd_s falling edge: start detection waits for the next tick in IDLE.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each bit is sampled at ticks S-1, S, S+1 and resolved by 2-of-3 majority at S+1.
  - All "sample point" decisions, including start validation and the final stop sample, occur at S+1.
  - valid is therefore one tick later.
- Undefined: single sample at tick S; the majority logic is not present.

Test Plan:
- 8N1, OVERSAMPLE=16, par_mode=0, send 0xA5 -> exactly one valid, rx_data=0xA5, parity_err=0, frame_err=0, busy low after the frame.
- Even parity, send 0x07 with parity bit 0 (correct is 1) -> valid, rx_data=0x07, parity_err=1. Odd parity with bit 0 -> parity_err=0.
- Stop bit driven low, send 0x3C -> valid, rx_data=0x3C, frame_err=1. Next frame 0x55 clean -> both flags 0.
- rxd low pulse of 4 ticks from idle -> no valid, busy returns 0 by tick 8; rx_data keeps the previous value.
- DATA_BITS=7, stop2=1: send 0x41 then 0x7F back-to-back -> two valid pulses, spacing >= 10 bit periods. Reset asserted mid-second frame -> all outputs 0 immediately.
- UART_RX_MAJORITY_EN defined: 1-tick glitch at tick S inside data bit 3 of 0x00 -> rx_data=0x00. Undefined: same stimulus -> rx_data=0x08.
